// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset/lock sequencer with staggered per-domain reset release; PLL_SUPERVISOR_STATS_EN adds lock-loss/timeout counters.
// Latency: lock pin changes act 3 refclk edges later (2-flop sync + registered outputs); no backpressure.
module pll_supervisor #(
    parameter int NUM_CLOCKS         = 3,
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int RST_STAGGER        = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            relock_count,
    output logic [7:0]            timeout_count
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter value on which RELEASE hands over to RUN (one past the last stagger step).
    localparam int REL_LAST = (NUM_CLOCKS - 1) * RST_STAGGER + 1;
    localparam int CNT_MAX  = max2(max2(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES),
                                   max2(RELOCK_TIMEOUT, REL_LAST));
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          locked_m;
    logic          locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            case (state)
                RESET_PLL: begin
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    if (cnt == CW'(RST_PULSE_CYCLES - 1)) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(RELOCK_TIMEOUT - 1)) begin
                        state   <= RESET_PLL;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss wins over any pending stagger step.
                    if (!locked_s) begin
                        state   <= RESET_PLL;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        rst_out <= '1;
                        ready   <= 1'b0;
                    end else if (state == RELEASE) begin
                        for (int i = 0; i < NUM_CLOCKS; i++) begin
                            if (cnt == CW'(i * RST_STAGGER)) begin
                                rst_out[i] <= 1'b0;
                            end
                        end
                        if (cnt == CW'(REL_LAST)) begin
                            state   <= RUN;
                            cnt     <= '0;
                            rst_out <= '0;
                            ready   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        pll_rst <= 1'b0;
                        rst_out <= '0;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state   <= RESET_PLL;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SUPERVISOR_STATS_EN
    logic relock_evt;
    logic timeout_evt;

    assign relock_evt  = (state == RUN) && !locked_s;
    assign timeout_evt = (state == WAIT_LOCK) && !locked_s && (cnt == CW'(RELOCK_TIMEOUT - 1));

    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_count  <= 8'd0;
            timeout_count <= 8'd0;
        end else begin
            if (relock_evt && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
            if (timeout_evt && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end
`else
    assign relock_count  = 8'd0;
    assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: scheduled output-change scoreboard plus direct status checks.
module tb_pll_supervisor;

    localparam int NCLK = 3;
    localparam int PULSE = 4;
    localparam int LSC = 16;
    localparam int TMO = 64;
    localparam int STG = 2;

    logic            refclk = 1'b0;
    logic            rst;
    logic            locked;
    logic            pll_rst;
    logic [NCLK-1:0] rst_out;
    logic            ready;
    logic [7:0]      relock_count;
    logic [7:0]      timeout_count;

    pll_supervisor #(
        .NUM_CLOCKS(NCLK),
        .RST_PULSE_CYCLES(PULSE),
        .LOCK_STABLE_CYCLES(LSC),
        .RELOCK_TIMEOUT(TMO),
        .RST_STAGGER(STG)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked(locked),
        .pll_rst(pll_rst),
        .rst_out(rst_out),
        .ready(ready),
        .relock_count(relock_count),
        .timeout_count(timeout_count)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } ev_t;
    ev_t sb[$];

    logic       mon_en = 1'b0;
    logic [4:0] prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] obs_now();
        return {pll_rst, rst_out, ready};
    endfunction

    function automatic logic [7:0] stat(input int v);
`ifdef PLL_SUPERVISOR_STATS_EN
        return 8'(v);
`else
        return 8'd0;
`endif
    endfunction

    task automatic push(input int c, input logic [4:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    // RELEASE entered on edge r: bits drop on r+1, r+1+STG, ..., ready one edge after the last.
    task automatic push_release(input int r);
        logic [2:0] v;
        for (int i = 0; i < NCLK; i++) begin
            v = 3'b111 << (i + 1);
            push(r + 1 + i * STG, {1'b0, v, 1'b0});
        end
        push(r + 1 + (NCLK - 1) * STG + 1, {1'b0, 3'b000, 1'b1});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    always @(negedge refclk) begin
        logic [4:0] o;
        ev_t e;
        if (mon_en) begin
            o = obs_now();
            if (o !== prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", {27'd0, o}, {27'd0, prev});
                end else begin
                    e = sb.pop_front();
                    check("out_val", {27'd0, o}, {27'd0, e.val});
                    check("out_cycle", cyc, e.cyc);
                end
                prev = o;
            end
        end
    end

    initial begin
        int t, l, d, r, w, rise;
        rst = 1'b1;
        locked = 1'b0;

        // Reset state
        wait_cyc(3);
        check("rst_pll_rst", {31'd0, pll_rst}, 1);
        check("rst_rst_out", {29'd0, rst_out}, 7);
        check("rst_ready", {31'd0, ready}, 0);
        check("rst_relock", {24'd0, relock_count}, 0);
        check("rst_timeout", {24'd0, timeout_count}, 0);
        prev = obs_now();
        mon_en = 1'b1;

        // Clean start
        t = cyc;
        rst = 1'b0;
        push(t + PULSE, 5'b0_111_0);
        l = t + 10;
        wait_cyc(l);
        locked = 1'b1;
        r = l + 3 + LSC;
        push_release(r);
        wait_cyc(r + 10);
        check("clean_sb_empty", sb.size(), 0);
        check("clean_ready", {31'd0, ready}, 1);

        // Lock loss in RUN
        d = cyc;
        locked = 1'b0;
        push(d + 3, 5'b1_111_0);
        push(d + 7, 5'b0_111_0);
        wait_cyc(d + 8);
        check("loss_relock", {24'd0, relock_count}, {24'd0, stat(1)});
        check("loss_timeout", {24'd0, timeout_count}, 0);
        check("loss_sb_empty", sb.size(), 0);

        // One-cycle glitch at stable count 10 restarts the stable window
        l = cyc;
        locked = 1'b1;
        wait_cyc(l + 11);
        locked = 1'b0;
        wait_cyc(l + 12);
        locked = 1'b1;
        r = l + 15 + LSC;
        push_release(r);
        wait_cyc(l + 20);
        check("glitch_hold_rst_out", {29'd0, rst_out}, 7);
        check("glitch_pll_rst", {31'd0, pll_rst}, 0);
        wait_cyc(r + 10);
        check("glitch_sb_empty", sb.size(), 0);
        check("glitch_relock", {24'd0, relock_count}, {24'd0, stat(1)});
        check("glitch_timeout", {24'd0, timeout_count}, 0);

        // Second loss, then rst asserted right after rst_out[0] clears
        d = cyc;
        locked = 1'b0;
        push(d + 3, 5'b1_111_0);
        push(d + 7, 5'b0_111_0);
        wait_cyc(d + 8);
        check("loss2_relock", {24'd0, relock_count}, {24'd0, stat(2)});
        l = cyc;
        locked = 1'b1;
        r = l + 3 + LSC;
        push(r + 1, 5'b0_110_0);
        push(r + 2, 5'b1_111_0);
        wait_cyc(r + 1);
        rst = 1'b1;
        wait_cyc(r + 2);
        rst = 1'b0;
        check("midrel_relock", {24'd0, relock_count}, 0);
        check("midrel_timeout", {24'd0, timeout_count}, 0);
        push(r + 2 + PULSE, 5'b0_111_0);
        push_release(r + 2 + PULSE + 1 + LSC);
        wait_cyc(r + 2 + PULSE + 1 + LSC + 10);
        check("midrel_sb_empty", sb.size(), 0);
        check("midrel_ready", {31'd0, ready}, 1);

        // Loss landing on the rst_out[1] stagger step
        d = cyc;
        locked = 1'b0;
        push(d + 3, 5'b1_111_0);
        push(d + 7, 5'b0_111_0);
        wait_cyc(d + 8);
        check("loss3_relock", {24'd0, relock_count}, {24'd0, stat(1)});
        l = cyc;
        locked = 1'b1;
        r = l + 3 + LSC;
        push(r + 1, 5'b0_110_0);
        wait_cyc(r);
        locked = 1'b0;
        push(r + 3, 5'b1_111_0);
        push(r + 7, 5'b0_111_0);
        wait_cyc(r + 8);
        check("relloss_relock", {24'd0, relock_count}, {24'd0, stat(1)});
        check("relloss_sb_empty", sb.size(), 0);

        // Repeated timeouts with locked held low; counter saturates at 255
        w = r + 7;
        for (int k = 0; k < 257; k++) begin
            rise = w + TMO + k * (TMO + PULSE);
            push(rise, 5'b1_111_0);
            push(rise + PULSE, 5'b0_111_0);
            wait_cyc(rise + PULSE + 1);
            check("timeout_count", {24'd0, timeout_count},
                  {24'd0, stat((k + 1 > 255) ? 255 : k + 1)});
        end
        wait_cyc(cyc + 5);
        check("timeout_sb_empty", sb.size(), 0);
        check("timeout_relock", {24'd0, relock_count}, {24'd0, stat(1)});

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 3: number of PLL output clock domains supervised (1..8).
REQ-002 SHALL have parameter RST_PULSE_CYCLES, default 16: PLL reset pulse length in refclk cycles (>=2).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release (>=2).
REQ-004 SHALL have parameter RELOCK_TIMEOUT, default 65536: maximum WAIT_LOCK cycles before PLL reset is retried (>=4).
REQ-005 SHALL have parameter RST_STAGGER, default 8: cycles between successive domain reset releases (>=1).
REQ-006 SHALL have port refclk  input  1  free-running reference clock; sole clock of the block.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port locked  input  1  PLL lock flag, asynchronous to refclk.
REQ-009 SHALL have port pll_rst  output  1  reset to the PLL, active-high.
REQ-010 SHALL have port rst_out  output  NUM_CLOCKS  per-domain reset, active-high, bit i for outclk_i.
REQ-011 SHALL have port ready  output  1  high only in RUN.
REQ-012 SHALL have port relock_count  output  8  number of lock losses in RUN, saturating.
REQ-013 SHALL have port timeout_count  output  8  number of WAIT_LOCK timeouts, saturating.

Function
REQ-014 SHALL synchronise locked through exactly two refclk flops into locked_s; all decisions use locked_s only.
REQ-015 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN with a single cycle counter cleared on every state change.
REQ-016 RESET_PLL: pll_rst=1, all rst_out=1; after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; counter reaching RELOCK_TIMEOUT-1 with locked_s=0 -> RESET_PLL and timeout_count+1.
REQ-018 STABLE: locked_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RELEASE; any locked_s=0 -> WAIT_LOCK (counter restarts, no PLL reset, no count increment).
REQ-019 RELEASE: rst_out[0] cleared on the first RELEASE edge, then rst_out[i] cleared RST_STAGGER cycles after rst_out[i-1], ascending index; after rst_out[NUM_CLOCKS-1] clears -> RUN on the next edge.
REQ-020 RUN: ready=1, all rst_out=0, pll_rst=0.
REQ-021 locked_s=0 in RELEASE or RUN SHALL set all rst_out=1 and ready=0 on the next edge and enter RESET_PLL; relock_count+1 only when the loss occurs in RUN.
REQ-022 Both counters SHALL saturate at 255 and never wrap.
REQ-023 Lock loss on the same cycle as a RELEASE stagger step SHALL take priority; no further bit is cleared.
REQ-024 Outputs SHALL be registered; rst_out bits SHALL never deassert out of index order.

Reset
REQ-025 rst=1 SHALL force the following on the next edge regardless of state: state=RESET_PLL, counter=0, pll_rst=1, rst_out=all ones, ready=0, both status counters=0, sync flops=0.
REQ-026 After rst deasserts, pll_rst SHALL remain high for RST_PULSE_CYCLES further cycles.
REQ-027 rst asserted mid-RELEASE SHALL reassert every already-cleared rst_out bit on the next edge.

Configuration
REQ-028 With macro PLL_SUPERVISOR_STATS_EN defined, relock_count and timeout_count SHALL operate per REQ-017/021/022.
REQ-029 Without PLL_SUPERVISOR_STATS_EN, relock_count and timeout_count SHALL be constant 0, no counter flops are synthesised, and FSM behaviour is unchanged.

Verification
Parameters for all scenarios: NUM_CLOCKS=3, RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=16, RELOCK_TIMEOUT=64, RST_STAGGER=2, PLL_SUPERVISOR_STATS_EN defined.
REQ-030 Clean start: release rst, assert locked at cycle 10 -> pll_rst low after 4 cycles; rst_out bits clear 0 then 1 then 2, 2 cycles apart, after 2-cycle sync plus 16 stable cycles; ready=1 one cycle after bit 2 clears.
REQ-031 Lock glitch: locked low for 1 cycle at stable count 10 -> FSM returns to WAIT_LOCK; release is delayed by a full 16 stable cycles; pll_rst stays 0; counts unchanged.
REQ-032 Timeout: locked held 0 -> pll_rst pulses 4 cycles every 68 cycles; timeout_count increments each pulse and holds at 255 after 255 pulses.
REQ-033 Loss in RUN: drop locked -> all rst_out=1 and ready=0 three edges later; relock_count=1; then normal relock sequence.
REQ-034 Reset mid-RELEASE: assert rst after rst_out[0] clears -> rst_out=3'b111, pll_rst=1 on the next edge; both counters read 0.
